// File: rtl/timer_pkg.sv
// Shared types and default sizes for the capture timer bank.
package timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t;

  localparam int unsigned TIMER_BITWIDTH_DEF = 32;
  localparam int unsigned NB_INTERFACES_DEF  = 10;

endpackage

// File: rtl/timer_channel.sv
// One capture timer channel: edge detect, run/done FSM, saturating counter,
// capture register and sticky compare alarm.
module timer_channel
  import timer_pkg::*;
#(
  parameter int unsigned TIMER_BITWIDTH = TIMER_BITWIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rst_capture,
  input  logic                      start,
  input  logic                      capture,
  input  logic                      alarm_en,
  input  logic [TIMER_BITWIDTH-1:0] alarm,
  output logic [TIMER_BITWIDTH-1:0] counter,
  output logic [TIMER_BITWIDTH-1:0] captured,
  output logic                      captured_valid,
  output logic                      overflow,
  output logic                      alarm_out
);

  localparam logic [TIMER_BITWIDTH-1:0] ALL_ONES = '1;

  timer_state_t              state;
  logic                      start_q;
  logic                      capture_q;
  logic                      start_rise;
  logic                      capture_rise;
  logic                      at_max;
  logic                      alarm_hit;
  logic [TIMER_BITWIDTH-1:0] count_inc;

  assign start_rise   = start & ~start_q;
  assign capture_rise = capture & ~capture_q;
  assign at_max       = (counter == ALL_ONES);
  assign count_inc    = at_max ? ALL_ONES : counter + 1'b1;
  assign alarm_hit    = alarm_en & (state == RUN) & (counter == alarm);

  // Priority: rst_capture, then start rise, then capture rise, then counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      start_q        <= 1'b0;
      capture_q      <= 1'b0;
      counter        <= '0;
      captured       <= '0;
      captured_valid <= 1'b0;
      overflow       <= 1'b0;
      alarm_out      <= 1'b0;
    end else begin
      start_q   <= start;
      capture_q <= capture;
      if (rst_capture) begin
        state          <= IDLE;
        counter        <= '0;
        captured       <= '0;
        captured_valid <= 1'b0;
        overflow       <= 1'b0;
        alarm_out      <= 1'b0;
      end else if (start_rise) begin
        state          <= RUN;
        counter        <= '0;
        captured_valid <= 1'b0;
        overflow       <= 1'b0;
        alarm_out      <= 1'b0;
      end else begin
        alarm_out <= alarm_en & (alarm_out | alarm_hit);
        case (state)
          RUN: begin
            if (capture_rise) begin
              // The capture edge itself counts as one more clock of width.
              captured       <= count_inc;
              captured_valid <= 1'b1;
              state          <= DONE;
            end else if (at_max) begin
              overflow <= 1'b1;
            end else begin
              counter <= count_inc;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/capture_timer_bank.sv
// Bank of independent capture timer channels on flattened per-channel buses.
module capture_timer_bank
  import timer_pkg::*;
#(
  parameter int unsigned TIMER_BITWIDTH = TIMER_BITWIDTH_DEF,
  parameter int unsigned NB_INTERFACES  = NB_INTERFACES_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NB_INTERFACES-1:0]              rst_capture,
  input  logic [NB_INTERFACES-1:0]              start,
  input  logic [NB_INTERFACES-1:0]              capture,
  input  logic [NB_INTERFACES-1:0]              alarm_en,
  input  logic [TIMER_BITWIDTH*NB_INTERFACES-1:0] alarm,
  output logic [TIMER_BITWIDTH*NB_INTERFACES-1:0] counter,
  output logic [TIMER_BITWIDTH*NB_INTERFACES-1:0] captured,
  output logic [NB_INTERFACES-1:0]              captured_valid,
  output logic [NB_INTERFACES-1:0]              overflow,
  output logic [NB_INTERFACES-1:0]              alarm_out
);

  for (genvar i = 0; i < NB_INTERFACES; i++) begin : g_ch
    timer_channel #(
      .TIMER_BITWIDTH(TIMER_BITWIDTH)
    ) u_channel (
      .clk            (clk),
      .rst            (rst),
      .rst_capture    (rst_capture[i]),
      .start          (start[i]),
      .capture        (capture[i]),
      .alarm_en       (alarm_en[i]),
      .alarm          (alarm[i*TIMER_BITWIDTH +: TIMER_BITWIDTH]),
      .counter        (counter[i*TIMER_BITWIDTH +: TIMER_BITWIDTH]),
      .captured       (captured[i*TIMER_BITWIDTH +: TIMER_BITWIDTH]),
      .captured_valid (captured_valid[i]),
      .overflow       (overflow[i]),
      .alarm_out      (alarm_out[i])
    );
  end

endmodule
